// File: rtl/rv32_flash_fetch_core.sv
// Multi-cycle RV32 core fetching over an AXI4-Lite read channel.
// Executes LUI and JAL; every other encoding and any errored fetch retires as a NOP.
module rv32_flash_fetch_core #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] araddr,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready,
  output logic            awvalid,
  output logic            wvalid,
  output logic            bready,
  output logic [XLEN-1:0] awaddr,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  output logic [2:0]      awprot,
  output logic [XLEN-1:0] reg_pc,
  output logic [XLEN-1:0] fetched_instruction,
  input  logic [4:0]      reg_read_sel,
  output logic [XLEN-1:0] reg_read_data
);

  localparam logic [6:0]      OPC_LUI = 7'b0110111;
  localparam logic [6:0]      OPC_JAL = 7'b1101111;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_RESP = 2'd1,
    EXECUTE    = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            arvalid_r;
  logic            rready_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_nxt_s;
  logic [XLEN-1:0] inst_r;
  logic            resp_err_r;
  logic [XLEN-1:0] xreg_r [0:31];
  logic            wr_en_s;
  logic [XLEN-1:0] wr_data_s;
  logic [4:0]      rd_s;
  logic [6:0]      opcode_s;
  logic [XLEN-1:0] jal_imm_s;
  logic            r_accept_s;

  assign opcode_s   = inst_r[6:0];
  assign rd_s       = inst_r[11:7];
  assign jal_imm_s  = {{(XLEN-20){inst_r[31]}}, inst_r[19:12], inst_r[20], inst_r[30:21], 1'b0};
  assign r_accept_s = rvalid && rready_r;

  assign araddr              = pc_r;
  assign arprot              = 3'b100;
  assign arvalid             = arvalid_r;
  assign rready              = rready_r;
  assign awvalid             = 1'b0;
  assign wvalid              = 1'b0;
  assign bready              = 1'b0;
  assign awaddr              = {XLEN{1'b0}};
  assign wdata               = {XLEN{1'b0}};
  assign wstrb               = 4'b0000;
  assign awprot              = 3'b000;
  assign reg_pc              = pc_r;
  assign fetched_instruction = inst_r;

  // Next-state decode for the fetch/execute sequence
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FETCH_REQ: begin
        if (arvalid_r && arready) begin
          state_nxt_s = FETCH_RESP;
        end else begin
          state_nxt_s = FETCH_REQ;
        end
      end
      FETCH_RESP: begin
        if (r_accept_s) begin
          state_nxt_s = EXECUTE;
        end else begin
          state_nxt_s = FETCH_RESP;
        end
      end
      EXECUTE: state_nxt_s = FETCH_REQ;
      default: state_nxt_s = FETCH_REQ;
    endcase
  end

  // State register; handshake strobes are registered from the next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= FETCH_REQ;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      arvalid_r <= (state_nxt_s == FETCH_REQ);
      rready_r  <= (state_nxt_s == FETCH_RESP);
    end
  end

  // Instruction capture; an error response still records the data word
  always_ff @(posedge clk) begin
    if (!rst) begin
      inst_r     <= {XLEN{1'b0}};
      resp_err_r <= 1'b0;
    end else if ((state_r == FETCH_RESP) && r_accept_s) begin
      inst_r     <= rdata;
      resp_err_r <= (rresp != 2'b00);
    end else begin
      inst_r     <= inst_r;
      resp_err_r <= resp_err_r;
    end
  end

  // Decode and execute; both LUI and JAL work from the pre-update PC
  always_comb begin
    wr_en_s   = 1'b0;
    wr_data_s = {XLEN{1'b0}};
    pc_nxt_s  = pc_r + PC_STEP;
    if (!resp_err_r) begin
      case (opcode_s)
        OPC_LUI: begin
          wr_en_s   = 1'b1;
          wr_data_s = {inst_r[31:12], {(XLEN-20){1'b0}}};
        end
        OPC_JAL: begin
          wr_en_s   = 1'b1;
          wr_data_s = pc_r + PC_STEP;
          pc_nxt_s  = pc_r + jal_imm_s;
        end
        default: begin
          wr_en_s = 1'b0;
        end
      endcase
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Program counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r <= RESET_PC;
    end else if (state_r == EXECUTE) begin
      pc_r <= pc_nxt_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Register file write-back; x0 is never written
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        xreg_r[i] <= {XLEN{1'b0}};
      end
    end else if ((state_r == EXECUTE) && wr_en_s && (rd_s != 5'd0)) begin
      xreg_r[rd_s] <= wr_data_s;
    end
  end

  // Debug read port
  always_comb begin
    reg_read_data = {XLEN{1'b0}};
    if (reg_read_sel != 5'd0) begin
      reg_read_data = xreg_r[reg_read_sel];
    end else begin
      reg_read_data = {XLEN{1'b0}};
    end
  end

endmodule

// File: tb/tb_rv32_flash_fetch_core.sv
// Self-checking bench: AXI4-Lite slave with programmable stalls plus an ISA reference
// model whose predicted fetch addresses are queued and compared at each AR handshake.
module tb_rv32_flash_fetch_core;

  logic        clk;
  logic        rst;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        awvalid;
  logic        wvalid;
  logic        bready;
  logic [31:0] awaddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot;
  logic [31:0] reg_pc;
  logic [31:0] fetched_instruction;
  logic [4:0]  reg_read_sel;
  logic [31:0] reg_read_data;

  int          checks_cnt;
  int          fails_cnt;
  logic [31:0] mem [0:15];
  logic [31:0] mreg [0:31];
  logic [31:0] mpc;
  logic [31:0] exp_q [$];

  rv32_flash_fetch_core dut (
    .clk                 (clk),
    .rst                 (rst),
    .araddr              (araddr),
    .arprot              (arprot),
    .arvalid             (arvalid),
    .arready             (arready),
    .rdata               (rdata),
    .rresp               (rresp),
    .rvalid              (rvalid),
    .rready              (rready),
    .awvalid             (awvalid),
    .wvalid              (wvalid),
    .bready              (bready),
    .awaddr              (awaddr),
    .wdata               (wdata),
    .wstrb               (wstrb),
    .awprot              (awprot),
    .reg_pc              (reg_pc),
    .fetched_instruction (fetched_instruction),
    .reg_read_sel        (reg_read_sel),
    .reg_read_data       (reg_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fails_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mpc = 32'h0000_0000;
    exp_q.delete();
    exp_q.push_back(mpc);
  endtask

  // Reference ISA step; pushes the next expected fetch address
  task automatic model_exec(input logic [31:0] inst, input logic err);
    logic [6:0]         opc;
    logic [4:0]         rd;
    logic signed [20:0] jimm;
    opc  = inst[6:0];
    rd   = inst[11:7];
    jimm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    if (!err && opc == 7'h37) begin
      if (rd != 5'd0) mreg[rd] = {inst[31:12], 12'h000};
      mpc = mpc + 32'd4;
    end else if (!err && opc == 7'h6F) begin
      if (rd != 5'd0) mreg[rd] = mpc + 32'd4;
      mpc = mpc + {{11{jimm[20]}}, jimm};
    end else begin
      mpc = mpc + 32'd4;
    end
    exp_q.push_back(mpc);
  endtask

  task automatic serve_fetch(input int ar_dly, input int r_dly, input logic [31:0] err_addr);
    logic [31:0] addr;
    logic [31:0] word;
    logic        err;
    int          wait_cnt;
    wait_cnt = 0;
    while (arvalid !== 1'b1 && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (arvalid !== 1'b1) begin
      check_eq("ar_timeout", {31'd0, arvalid}, 32'd1);
      return;
    end
    addr = araddr;
    if (exp_q.size() > 0) check_eq("araddr", araddr, exp_q.pop_front());
    check_eq("arprot", {29'd0, arprot}, 32'd4);
    repeat (ar_dly) begin
      @(negedge clk);
      check_eq("ar_hold_valid", {31'd0, arvalid}, 32'd1);
      check_eq("ar_hold_addr", araddr, addr);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    repeat (r_dly) begin
      check_eq("one_outstanding", {31'd0, arvalid}, 32'd0);
      @(negedge clk);
    end
    word = mem[addr[5:2]];
    err  = (addr == err_addr);
    check_eq("rready", {31'd0, rready}, 32'd1);
    rdata  = word;
    rresp  = err ? 2'b10 : 2'b00;
    rvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    rresp  = 2'b00;
    check_eq("fetched", fetched_instruction, word);
    model_exec(word, err);
  endtask

  task automatic run_fetches(input int n, input int ar_dly, input int r_dly, input logic [31:0] err_addr);
    for (int k = 0; k < n; k++) serve_fetch(ar_dly, r_dly, err_addr);
    @(negedge clk);
    check_eq("reg_pc", reg_pc, mpc);
  endtask

  task automatic verify_regs();
    for (int i = 0; i < 32; i++) begin
      reg_read_sel = i[4:0];
      #1;
      check_eq($sformatf("x%0d", i), reg_read_data, mreg[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    arready = 1'b0;
    rvalid  = 1'b0;
    repeat (2) @(negedge clk);
    reset_model();
  endtask

  task automatic load_prog_a();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0000;
    mem[0] = 32'hABCDE137;
    mem[1] = 32'hFFDFF0EF;
    mem[2] = 32'hFFFFF137;
  endtask

  initial begin
    checks_cnt   = 0;
    fails_cnt    = 0;
    rst          = 1'b0;
    arready      = 1'b0;
    rvalid       = 1'b0;
    rdata        = 32'd0;
    rresp        = 2'b00;
    reg_read_sel = 5'd0;

    // LUI/JAL loop, zero wait states
    load_prog_a();
    do_reset();
    rst = 1'b1;
    run_fetches(20, 0, 0, 32'hFFFF_FFFF);
    verify_regs();
    reg_read_sel = 5'd1; #1;
    check_eq("x1_link", reg_read_data, 32'h0000_0008);
    reg_read_sel = 5'd2; #1;
    check_eq("x2_lui", reg_read_data, 32'hABCDE000);

    // Reset asserted mid-transaction clears all architectural state
    do_reset();
    check_eq("rst_pc", reg_pc, 32'h0000_0000);
    check_eq("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check_eq("rst_rready", {31'd0, rready}, 32'd0);
    check_eq("rst_fetched", fetched_instruction, 32'h0000_0000);
    for (int i = 0; i < 32; i++) begin
      reg_read_sel = i[4:0];
      #1;
      check_eq("rst_xreg", reg_read_data, 32'h0000_0000);
    end
    @(negedge clk);
    rst = 1'b1;

    // Same program under slave stalls
    run_fetches(10, 5, 7, 32'hFFFF_FFFF);
    verify_regs();
    reg_read_sel = 5'd1; #1;
    check_eq("stall_x1", reg_read_data, 32'h0000_0008);

    // x0 write, NOP opcodes, error response on LUI x5
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0000;
    mem[0] = 32'h12345037;
    mem[1] = 32'h00000013;
    mem[2] = 32'h000052B7;
    do_reset();
    rst = 1'b1;
    run_fetches(5, 1, 2, 32'h0000_0008);
    verify_regs();
    reg_read_sel = 5'd5; #1;
    check_eq("err_x5", reg_read_data, 32'h0000_0000);
    check_eq("err_pc", reg_pc, 32'h0000_0014);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fails_cnt);
    $finish;
  end

endmodule
